// File: rtl/output_pkg.sv
// rtl/output_pkg.sv - shared seven-segment constants and formatter state type
package output_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_ENCODE  = 2'd2
  } fmt_state_t;

  // Segment byte, msb..lsb = a,b,c,d,e,f,g,dp; a 0 lights the segment.
  localparam logic [7:0] SEG_BLANK = 8'b11111111;
  localparam logic [7:0] SEG_MINUS = 8'b11111101;
  localparam logic [7:0] SEG_E     = 8'b01100001;
  localparam logic [7:0] SEG_R     = 8'b11110101;

  function automatic logic [7:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    seg_digit = 8'b00000011;
      4'd1:    seg_digit = 8'b10011111;
      4'd2:    seg_digit = 8'b00100101;
      4'd3:    seg_digit = 8'b00001101;
      4'd4:    seg_digit = 8'b10011001;
      4'd5:    seg_digit = 8'b01001001;
      4'd6:    seg_digit = 8'b01000001;
      4'd7:    seg_digit = 8'b00011111;
      4'd8:    seg_digit = 8'b00000001;
      4'd9:    seg_digit = 8'b00001001;
      default: seg_digit = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/output_bin2bcd.sv
// rtl/output_bin2bcd.sv - serial 16-bit binary to 5-digit BCD converter
// One shift/add-3 step per cycle; o_done flags the cycle whose edge completes the result.
module output_bin2bcd (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [15:0] i_bin,
  output logic        o_busy,
  output logic        o_done,
  output logic [19:0] o_bcd
);

  logic        r_busy;
  logic [3:0]  r_cnt;
  logic [15:0] r_bin;
  logic [19:0] r_bcd;
  logic [19:0] w_adj;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 5; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5) w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_bin  <= '0;
      r_bcd  <= '0;
    end else if (r_busy) begin
      {r_bcd, r_bin} <= {w_adj[18:0], r_bin, 1'b0};
      r_cnt          <= r_cnt + 4'd1;
      if (r_cnt == 4'd15) r_busy <= 1'b0;
    end else if (i_start) begin
      r_bin  <= i_bin;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_busy && (r_cnt == 4'd15);
  assign o_bcd  = r_bcd;

endmodule

// File: rtl/output_formatter.sv
// rtl/output_formatter.sv - signed value to four seven-segment patterns with dp and blink
// Patterns only change at the ENCODE edge, so the display never shows partial conversions.
module output_formatter
  import output_pkg::*;
#(
  parameter int BLINK_DIV = 25000000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        blink_en,
  input  logic        dp_en,
  input  logic [1:0]  dp_pos,
  output logic        busy,
  output logic        overflow,
  output logic [7:0]  oct0,
  output logic [7:0]  oct1,
  output logic [7:0]  oct2,
  output logic [7:0]  oct3
);

  localparam int CW = $clog2(BLINK_DIV);

  fmt_state_t      r_state, w_next;
  logic            r_busy, r_sign, r_overflow, r_phase;
  logic [CW-1:0]   r_blink_cnt;
  logic [7:0]      r_oct [4];
  logic [7:0]      w_pat [4];
  logic [7:0]      w_out [4];
  logic            w_start, w_cvt_busy, w_done, w_ovf;
  logic [15:0]     w_mag;
  logic [19:0]     w_bcd;
  logic [1:0]      w_first;

  assign w_mag = value[15] ? (~value + 16'd1) : value;

  output_bin2bcd u_bin2bcd (
    .clk     (Clock),
    .rst     (Reset),
    .i_start (w_start),
    .i_bin   (w_mag),
    .o_busy  (w_cvt_busy),
    .o_done  (w_done),
    .o_bcd   (w_bcd)
  );

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    case (r_state)
      ST_IDLE:    if (load && !w_cvt_busy) begin
                    w_start = 1'b1;
                    w_next  = ST_CONVERT;
                  end
      ST_CONVERT: if (w_done) w_next = ST_ENCODE;
      ST_ENCODE:  w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_sign  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != ST_IDLE);
      if (w_start) r_sign <= value[15];
    end
  end

  // Leftmost shown digit: first nonzero of the thousands..tens, else units.
  always_comb begin
    w_first = 2'd3;
    for (int p = 2; p >= 0; p--) begin
      if (w_bcd[(3-p)*4 +: 4] != 4'd0) w_first = 2'(p);
    end
  end

  always_comb begin
    w_ovf = (w_bcd[19:16] != 4'd0) || (r_sign && (w_bcd[15:12] != 4'd0));
    for (int p = 0; p < 4; p++) begin
      w_pat[p] = SEG_BLANK;
      if (p >= int'(w_first))                          w_pat[p] = seg_digit(w_bcd[(3-p)*4 +: 4]);
      else if (r_sign && (p == int'(w_first) - 1))     w_pat[p] = SEG_MINUS;
    end
    if (w_ovf) begin
      w_pat[0] = SEG_E;
      w_pat[1] = SEG_R;
      w_pat[2] = SEG_R;
      w_pat[3] = SEG_BLANK;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_overflow <= 1'b0;
      r_oct[0]   <= SEG_BLANK;
      r_oct[1]   <= SEG_BLANK;
      r_oct[2]   <= SEG_BLANK;
      r_oct[3]   <= seg_digit(4'd0);
    end else if (r_state == ST_ENCODE) begin
      r_overflow <= w_ovf;
      for (int p = 0; p < 4; p++) r_oct[p] <= w_pat[p];
    end
  end

  // Held at phase-on while disabled so blinking always starts visible.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else if (!blink_en) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else if (r_blink_cnt == CW'(BLINK_DIV - 1)) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + CW'(1);
    end
  end

  always_comb begin
    for (int p = 0; p < 4; p++) begin
      w_out[p] = r_oct[p];
      if (dp_en && !r_overflow && (dp_pos == 2'(p))) w_out[p][0] = 1'b0;
      if (blink_en && !r_phase)                       w_out[p]    = SEG_BLANK;
    end
  end

  assign busy     = r_busy;
  assign overflow = r_overflow;
  assign oct0     = w_out[0];
  assign oct1     = w_out[1];
  assign oct2     = w_out[2];
  assign oct3     = w_out[3];

endmodule

// File: tb/tb_output_formatter.sv
// tb/tb_output_formatter.sv - scoreboard bench for output_formatter
module tb_output_formatter;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic        blink_en = 1'b0;
  logic        dp_en = 1'b0;
  logic [1:0]  dp_pos = '0;
  logic        busy, overflow;
  logic [7:0]  oct0, oct1, oct2, oct3;

  output_formatter #(.BLINK_DIV(4)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .load     (load),
    .value    (value),
    .blink_en (blink_en),
    .dp_en    (dp_en),
    .dp_pos   (dp_pos),
    .busy     (busy),
    .overflow (overflow),
    .oct0     (oct0),
    .oct1     (oct1),
    .oct2     (oct2),
    .oct3     (oct3)
  );

  always #5 Clock = ~Clock;

  localparam logic [7:0] BL = 8'b11111111;
  localparam logic [7:0] MN = 8'b11111101;
  localparam logic [7:0] EE = 8'b01100001;
  localparam logic [7:0] RR = 8'b11110101;
  logic [7:0] digtab [10] = '{8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101, 8'b10011001,
                              8'b01001001, 8'b01000001, 8'b00011111, 8'b00000001, 8'b00001001};

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];

  // {overflow, oct0, oct1, oct2, oct3} written right-to-left from the decimal digits
  function automatic logic [32:0] model(int v);
    logic [7:0] p [4];
    int mag, pos;
    bit neg;
    neg = (v < 0);
    mag = neg ? -v : v;
    if ((!neg && mag > 9999) || (neg && mag > 999)) return {1'b1, EE, RR, RR, BL};
    for (int i = 0; i < 4; i++) p[i] = BL;
    pos = 3;
    do begin
      p[pos] = digtab[mag % 10];
      mag = mag / 10;
      pos--;
    end while (mag > 0);
    if (neg) p[pos] = MN;
    return {1'b0, p[0], p[1], p[2], p[3]};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_octs(string tag, logic [32:0] e);
    chk({tag, ".oct0"}, 32'(oct0), 32'(e[31:24]));
    chk({tag, ".oct1"}, 32'(oct1), 32'(e[23:16]));
    chk({tag, ".oct2"}, 32'(oct2), 32'(e[15:8]));
    chk({tag, ".oct3"}, 32'(oct3), 32'(e[7:0]));
    chk({tag, ".overflow"}, 32'(overflow), 32'(e[32]));
  endtask

  // Monitor: on every completed conversion check busy length and pop the expected patterns.
  bit prev_busy = 1'b0;
  int bcnt = 0;
  always @(negedge Clock) begin
    if (Reset) begin
      prev_busy = 1'b0;
      bcnt = 0;
    end else begin
      if (busy) bcnt++;
      else if (prev_busy) begin
        chk("busy_cycles", 32'(bcnt), 32'd17);
        if (exp_q.size() == 0) chk("unexpected_result", 32'(exp_q.size()), 32'd1);
        else chk_octs("result", exp_q.pop_front());
        bcnt = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic do_load(int v, bit accept);
    @(negedge Clock);
    load = 1'b1;
    value = 16'(v);
    if (accept) exp_q.push_back(model(v));
    @(negedge Clock);
    load = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(negedge Clock);
      n++;
    end
    if (busy) chk("wait_idle_timeout", 32'(busy), 32'd0);
    @(negedge Clock);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [32:0] e;
    int v, cat;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    #1;
    chk_octs("reset", {1'b0, BL, BL, BL, digtab[0]});
    chk("reset.busy", 32'(busy), 32'd0);

    do_load(1234, 1'b1);  wait_idle();
    do_load(-45, 1'b1);   wait_idle();
    do_load(0, 1'b1);     wait_idle();
    do_load(-999, 1'b1);  wait_idle();
    do_load(10000, 1'b1); wait_idle();
    do_load(-1000, 1'b1); wait_idle();
    do_load(-32768, 1'b1); wait_idle();

    dp_en = 1'b1;
    dp_pos = 2'd2;
    #1 chk_octs("dp_ignored_on_overflow", {1'b1, EE, RR, RR, BL});
    dp_en = 1'b0;

    do_load(7, 1'b1);     wait_idle();

    do_load(1234, 1'b1);
    repeat (3) @(negedge Clock);
    do_load(5678, 1'b0);
    wait_idle();

    dp_en = 1'b1;
    for (int p = 0; p < 4; p++) begin
      dp_pos = 2'(p);
      e = model(1234);
      e[(3-p)*8] = 1'b0;
      #1 chk_octs("dp", e);
    end
    dp_pos = 2'd1;
    #1 chk("dp_oct1", 32'(oct1), 32'b00100100);
    dp_en = 1'b0;

    @(negedge Clock);
    blink_en = 1'b1;
    e = model(1234);
    for (int k = 0; k < 16; k++) begin
      #1 chk_octs("blink", ((k / 4) % 2 == 0) ? e : {1'b0, BL, BL, BL, BL});
      @(negedge Clock);
    end
    blink_en = 1'b0;
    #1 chk_octs("blink_off", e);

    do_load(4321, 1'b1);
    repeat (7) @(posedge Clock);
    #2 Reset = 1'b1;
    #1;
    chk_octs("reset_mid", {1'b0, BL, BL, BL, digtab[0]});
    chk("reset_mid.busy", 32'(busy), 32'd0);
    exp_q.delete();
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    repeat (20) @(negedge Clock);
    chk_octs("after_abort", {1'b0, BL, BL, BL, digtab[0]});
    chk("after_abort.busy", 32'(busy), 32'd0);

    for (int i = 0; i < 30; i++) begin
      cat = int'($urandom_range(0, 4));
      case (cat)
        0:       v = int'($urandom_range(0, 9999));
        1:       v = -int'($urandom_range(1, 999));
        2:       v = int'($urandom_range(10000, 32767));
        3:       v = -int'($urandom_range(1000, 32768));
        default: v = int'($urandom_range(0, 108)) - 9;
      endcase
      do_load(v, 1'b1);
      wait_idle();
    end

    repeat (3) @(negedge Clock);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
